// File: rtl/gobang_move_ctrl.sv
// gobang_move_ctrl: move sequencer for the gobang game.
// Owns the turn, arbitrates human/AI move requests, checks the target cell
// through the datapath consider port, and issues write/retract/clr pulses
// plus the win-checker start.
// Optional undo support is compiled in when GOBANG_RETRACT_EN is defined.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | after reset, waiting for start
// S_CLEAR     | clr pulse out, board and counter being cleared
// S_WAIT_MOVE | waiting for a request from the side to move
// S_QUERY     | consider_* driven, datapath responding
// S_CHECK     | grid_i[4] sampled: empty -> write, occupied -> reject
// S_WRITE     | write pulse out, ply counted
// S_JUDGE     | chk_start pulsed, waiting for chk_done
// S_RETRACT   | undo pulses in progress (GOBANG_RETRACT_EN only)
// S_OVER      | game ended by win or draw, held until start

module gobang_move_ctrl #(
    parameter int MAX_MOVES = 225,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_p,
    input  logic             start,
    input  logic             black_is_player,
    input  logic             white_is_player,
    input  logic             hum_req,
    input  logic [3:0]       hum_i,
    input  logic [3:0]       hum_j,
    input  logic             ai_req,
    input  logic [3:0]       ai_i,
    input  logic [3:0]       ai_j,
    input  logic             retract_req,
    input  logic [8:0]       grid_i,
    input  logic             chk_done,
    input  logic             chk_win,
    output logic [3:0]       consider_i,
    output logic [3:0]       consider_j,
    output logic             clr,
    output logic             write,
    output logic [3:0]       write_i,
    output logic [3:0]       write_j,
    output logic             write_color,
    output logic             retract,
    output logic             ai_start,
    output logic             chk_start,
    output logic             reject,
    output logic             crt_player,
    output logic             game_running,
    output logic [1:0]       winner,
    output logic [CNT_W-1:0] move_cnt
);

    localparam logic [CNT_W-1:0] LP_MAX_MOVES = CNT_W'(MAX_MOVES);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT_MOVE,
        S_QUERY,
        S_CHECK,
        S_WRITE,
        S_JUDGE,
`ifdef GOBANG_RETRACT_EN
        S_RETRACT,
`endif
        S_OVER
    } state_t;

    state_t           r_state;
    logic             r_black_hum;
    logic             r_white_hum;
    logic [3:0]       r_con_i;
    logic [3:0]       r_con_j;
    logic             r_clr;
    logic             r_write;
    logic [3:0]       r_write_i;
    logic [3:0]       r_write_j;
    logic             r_write_color;
    logic             r_ai_start;
    logic             r_chk_start;
    logic             r_reject;
    logic             r_crt_player;
    logic             r_game_running;
    logic [1:0]       r_winner;
    logic [CNT_W-1:0] r_move_cnt;

    logic             w_owner_hum;
    logic             w_next_owner_hum;
    logic             w_req;
    logic [3:0]       w_req_i;
    logic [3:0]       w_req_j;
    logic             w_req_bad;
    logic [CNT_W-1:0] w_cnt_inc;

    // Turn ownership and request selection from the side to move.
    assign w_owner_hum      = r_crt_player ? r_white_hum : r_black_hum;
    assign w_next_owner_hum = r_crt_player ? r_black_hum : r_white_hum;
    assign w_req            = w_owner_hum ? hum_req : ai_req;
    assign w_req_i          = w_owner_hum ? hum_i : ai_i;
    assign w_req_j          = w_owner_hum ? hum_j : ai_j;
    assign w_req_bad        = (w_req_i > 4'd14) || (w_req_j > 4'd14);
    // The counter holds at all-ones rather than wrapping.
    assign w_cnt_inc        = (r_move_cnt == {CNT_W{1'b1}}) ? r_move_cnt
                                                           : r_move_cnt + 1'b1;

`ifdef GOBANG_RETRACT_EN
    logic             r_retract;
    logic             r_ret_more;
    logic             w_two_ply;
    logic [CNT_W-1:0] w_plies;
    logic             w_ret_ok;

    // Human-vs-human undoes one ply; otherwise the AI reply goes too.
    assign w_two_ply = ~(r_black_hum & r_white_hum);
    assign w_plies   = w_two_ply ? CNT_W'(2) : CNT_W'(1);
    assign w_ret_ok  = retract_req && w_owner_hum && (r_move_cnt >= w_plies);
    assign retract   = r_retract;

    // Only the centre bit of the row window is needed here.
    logic w_unused_in;
    assign w_unused_in = ^{grid_i[8:5], grid_i[3:0]};
`else
    assign retract = 1'b0;

    // Undo input and the neighbouring window bits are not used in this build.
    logic w_unused_in;
    assign w_unused_in = ^{retract_req, grid_i[8:5], grid_i[3:0]};
`endif

    // Sequencer FSM with all outputs registered; start overrides every state.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            r_state        <= S_IDLE;
            r_black_hum    <= 1'b0;
            r_white_hum    <= 1'b0;
            r_con_i        <= 4'd0;
            r_con_j        <= 4'd0;
            r_clr          <= 1'b0;
            r_write        <= 1'b0;
            r_write_i      <= 4'd0;
            r_write_j      <= 4'd0;
            r_write_color  <= 1'b0;
            r_ai_start     <= 1'b0;
            r_chk_start    <= 1'b0;
            r_reject       <= 1'b0;
            r_crt_player   <= 1'b0;
            r_game_running <= 1'b0;
            r_winner       <= 2'b00;
            r_move_cnt     <= '0;
`ifdef GOBANG_RETRACT_EN
            r_retract      <= 1'b0;
            r_ret_more     <= 1'b0;
`endif
        end else begin
            r_clr       <= 1'b0;
            r_write     <= 1'b0;
            r_ai_start  <= 1'b0;
            r_chk_start <= 1'b0;
            r_reject    <= 1'b0;
`ifdef GOBANG_RETRACT_EN
            r_retract   <= 1'b0;
`endif
            if (start) begin
                r_state        <= S_CLEAR;
                r_black_hum    <= black_is_player;
                r_white_hum    <= white_is_player;
                r_clr          <= 1'b1;
                r_move_cnt     <= '0;
                r_winner       <= 2'b00;
                r_crt_player   <= 1'b0;
                r_game_running <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end
                    S_CLEAR: begin
                        r_ai_start <= ~r_black_hum;
                        r_state    <= S_WAIT_MOVE;
                    end
                    S_WAIT_MOVE: begin
`ifdef GOBANG_RETRACT_EN
                        if (w_ret_ok) begin
                            r_retract    <= 1'b1;
                            r_move_cnt   <= r_move_cnt - 1'b1;
                            r_crt_player <= ~r_crt_player;
                            r_ret_more   <= w_two_ply;
                            r_state      <= S_RETRACT;
                        end else
`endif
                        if (w_req) begin
                            if (w_req_bad) begin
                                r_reject <= 1'b1;
                            end else begin
                                r_con_i <= w_req_i;
                                r_con_j <= w_req_j;
                                r_state <= S_QUERY;
                            end
                        end
                    end
                    S_QUERY: begin
                        r_state <= S_CHECK;
                    end
                    S_CHECK: begin
                        if (grid_i[4]) begin
                            r_write       <= 1'b1;
                            r_write_i     <= r_con_i;
                            r_write_j     <= r_con_j;
                            r_write_color <= r_crt_player;
                            r_state       <= S_WRITE;
                        end else begin
                            // Occupied: the owner retries on its own, no new ai_start.
                            r_reject <= 1'b1;
                            r_state  <= S_WAIT_MOVE;
                        end
                    end
                    S_WRITE: begin
                        r_move_cnt  <= w_cnt_inc;
                        r_chk_start <= 1'b1;
                        r_state     <= S_JUDGE;
                    end
                    S_JUDGE: begin
                        if (chk_done) begin
                            if (chk_win) begin
                                r_winner       <= r_crt_player ? 2'b01 : 2'b10;
                                r_game_running <= 1'b0;
                                r_state        <= S_OVER;
                            end else if (r_move_cnt == LP_MAX_MOVES) begin
                                r_winner       <= 2'b00;
                                r_game_running <= 1'b0;
                                r_state        <= S_OVER;
                            end else begin
                                r_crt_player <= ~r_crt_player;
                                r_ai_start   <= ~w_next_owner_hum;
                                r_state      <= S_WAIT_MOVE;
                            end
                        end
                    end
`ifdef GOBANG_RETRACT_EN
                    S_RETRACT: begin
                        if (r_ret_more) begin
                            r_retract    <= 1'b1;
                            r_move_cnt   <= r_move_cnt - 1'b1;
                            r_crt_player <= ~r_crt_player;
                            r_ret_more   <= 1'b0;
                        end else begin
                            r_state <= S_WAIT_MOVE;
                        end
                    end
`endif
                    S_OVER: begin
                        r_state <= S_OVER;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign consider_i   = r_con_i;
    assign consider_j   = r_con_j;
    assign clr          = r_clr;
    assign write        = r_write;
    assign write_i      = r_write_i;
    assign write_j      = r_write_j;
    assign write_color  = r_write_color;
    assign ai_start     = r_ai_start;
    assign chk_start    = r_chk_start;
    assign reject       = r_reject;
    assign crt_player   = r_crt_player;
    assign game_running = r_game_running;
    assign winner       = r_winner;
    assign move_cnt     = r_move_cnt;

endmodule

// File: tb/tb_gobang_move_ctrl.sv
// Testbench for gobang_move_ctrl: directed game sequences, with expected
// writes queued at request time and compared when the write pulse appears.

module tb_gobang_move_ctrl;

    logic       clk = 1'b0;
    logic       rst_p;
    logic       start;
    logic       black_is_player;
    logic       white_is_player;
    logic       hum_req;
    logic [3:0] hum_i;
    logic [3:0] hum_j;
    logic       ai_req;
    logic [3:0] ai_i;
    logic [3:0] ai_j;
    logic       retract_req;
    logic [8:0] grid_i;
    logic       chk_done;
    logic       chk_win;
    logic [3:0] consider_i;
    logic [3:0] consider_j;
    logic       clr;
    logic       write;
    logic [3:0] write_i;
    logic [3:0] write_j;
    logic       write_color;
    logic       retract;
    logic       ai_start;
    logic       chk_start;
    logic       reject;
    logic       crt_player;
    logic       game_running;
    logic [1:0] winner;
    logic [7:0] move_cnt;

    gobang_move_ctrl dut (
        .clk             (clk),
        .rst_p           (rst_p),
        .start           (start),
        .black_is_player (black_is_player),
        .white_is_player (white_is_player),
        .hum_req         (hum_req),
        .hum_i           (hum_i),
        .hum_j           (hum_j),
        .ai_req          (ai_req),
        .ai_i            (ai_i),
        .ai_j            (ai_j),
        .retract_req     (retract_req),
        .grid_i          (grid_i),
        .chk_done        (chk_done),
        .chk_win         (chk_win),
        .consider_i      (consider_i),
        .consider_j      (consider_j),
        .clr             (clr),
        .write           (write),
        .write_i         (write_i),
        .write_j         (write_j),
        .write_color     (write_color),
        .retract         (retract),
        .ai_start        (ai_start),
        .chk_start       (chk_start),
        .reject          (reject),
        .crt_player      (crt_player),
        .game_running    (game_running),
        .winner          (winner),
        .move_cnt        (move_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_clr = 0;
    int n_write = 0;
    int n_reject = 0;
    int n_ai_start = 0;
    int n_chk_start = 0;
    int n_retract = 0;
    logic p_clr = 1'b0, p_write = 1'b0, p_reject = 1'b0, p_ai = 1'b0, p_chk = 1'b0;
    logic [8:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor and write scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        logic [8:0] e;
        if (write) begin
            n_write++;
            if (exp_q.size() == 0) begin
                check("write_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("write_data", {write_i, write_j, write_color}, e);
            end
            check("write_width", p_write, 0);
        end
        if (clr) begin n_clr++; check("clr_width", p_clr, 0); end
        if (reject) begin n_reject++; check("reject_width", p_reject, 0); end
        if (ai_start) begin n_ai_start++; check("ai_start_width", p_ai, 0); end
        if (chk_start) begin n_chk_start++; check("chk_start_width", p_chk, 0); end
        if (retract) n_retract++;
        p_clr = clr; p_write = write; p_reject = reject; p_ai = ai_start; p_chk = chk_start;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_game(input logic bh, input logic wh);
        black_is_player = bh;
        white_is_player = wh;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_clr", clr, 1);
        check("start_running", game_running, 1);
        check("start_player", crt_player, 0);
        check("start_cnt", move_cnt, 0);
        tick();
        check("clr_end", clr, 0);
    endtask

    // One full legal move: request, query, write, judge.
    task automatic play(input logic ai, input logic [3:0] i, input logic [3:0] j,
                        input logic col, input logic win);
        grid_i = 9'h1FF;
        exp_q.push_back({i, j, col});
        if (ai) begin ai_req = 1'b1; ai_i = i; ai_j = j; end
        else begin hum_req = 1'b1; hum_i = i; hum_j = j; end
        tick();
        ai_req = 1'b0;
        hum_req = 1'b0;
        check("consider_i", consider_i, i);
        check("consider_j", consider_j, j);
        tick();
        check("write_early", write, 0);
        tick();
        check("write_cycle3", write, 1);
        tick();
        check("chk_start_cycle4", chk_start, 1);
        chk_done = 1'b1;
        chk_win = win;
        tick();
        chk_done = 1'b0;
        chk_win = 1'b0;
    endtask

    initial begin
        int w0, r0, a0, t0;
        rst_p = 1'b1; start = 1'b0; black_is_player = 1'b0; white_is_player = 1'b0;
        hum_req = 1'b0; hum_i = 4'd0; hum_j = 4'd0; ai_req = 1'b0; ai_i = 4'd0; ai_j = 4'd0;
        retract_req = 1'b0; grid_i = 9'h1FF; chk_done = 1'b0; chk_win = 1'b0;
        repeat (3) tick();
        check("rst_player", crt_player, 0);
        check("rst_running", game_running, 0);
        check("rst_winner", winner, 0);
        check("rst_cnt", move_cnt, 0);
        check("rst_consider", {consider_i, consider_j}, 0);
        check("rst_write", {write, write_i, write_j, write_color}, 0);
        rst_p = 1'b0;
        tick();

        // Game 1: human vs human.
        start_game(1'b1, 1'b1);
        play(1'b0, 4'd7, 4'd7, 1'b0, 1'b0);
        check("g1_player_after_black", crt_player, 1);
        check("g1_cnt1", move_cnt, 1);

        w0 = n_write; r0 = n_reject;
        grid_i = 9'h1EF;
        hum_req = 1'b1; hum_i = 4'd7; hum_j = 4'd7;
        tick();
        hum_req = 1'b0;
        tick();
        tick();
        check("occupied_reject", reject, 1);
        tick();
        check("occupied_reject_end", reject, 0);
        check("occupied_no_write", n_write, w0);
        check("occupied_player", crt_player, 1);
        check("occupied_cnt", move_cnt, 1);

        grid_i = 9'h1FF;
        hum_req = 1'b1; hum_i = 4'd15; hum_j = 4'd3;
        tick();
        hum_req = 1'b0;
        check("range_i_reject", reject, 1);
        check("range_i_no_query", consider_i, 7);
        tick();
        hum_req = 1'b1; hum_i = 4'd3; hum_j = 4'd15;
        tick();
        hum_req = 1'b0;
        check("range_j_reject", reject, 1);
        tick();
        check("reject_total", n_reject, r0 + 3);

        play(1'b0, 4'd14, 4'd14, 1'b1, 1'b0);
        check("g1_player_after_white", crt_player, 0);
        check("g1_cnt2", move_cnt, 2);
        check("g1_no_ai_start", n_ai_start, 0);

        // Game 2: human black, AI white; white wins.
        start_game(1'b1, 1'b0);
        check("g2_no_ai_for_black", n_ai_start, 0);
        play(1'b0, 4'd7, 4'd7, 1'b0, 1'b0);
        tick();
        check("g2_ai_start_once", n_ai_start, 1);
        w0 = n_write; r0 = n_reject;
        hum_req = 1'b1; hum_i = 4'd1; hum_j = 4'd1;
        tick();
        hum_i = 4'd15;
        tick();
        hum_req = 1'b0;
        repeat (3) tick();
        check("g2_hum_ignored_write", n_write, w0);
        check("g2_hum_ignored_reject", n_reject, r0);
        check("g2_ai_start_still_once", n_ai_start, 1);
        play(1'b1, 4'd8, 4'd8, 1'b1, 1'b1);
        check("g2_winner_white", winner, 2'b01);
        check("g2_not_running", game_running, 0);
        check("g2_cnt", move_cnt, 2);
        w0 = n_write; r0 = n_reject; a0 = n_ai_start;
        hum_req = 1'b1; hum_i = 4'd3; hum_j = 4'd3;
        ai_req = 1'b1; ai_i = 4'd4; ai_j = 4'd4;
        repeat (4) tick();
        hum_req = 1'b0; ai_req = 1'b0;
        repeat (3) tick();
        check("over_no_write", n_write, w0);
        check("over_no_reject", n_reject, r0);
        check("over_no_ai_start", n_ai_start, a0);
        check("over_winner_held", winner, 2'b01);

        // Game 3: human vs human to a full-board draw.
        start_game(1'b1, 1'b1);
        check("g3_clr_count", n_clr, 3);
        for (int k = 0; k < 225; k++) begin
            play(1'b0, 4'(k / 15), 4'(k % 15), k[0], 1'b0);
            if (k == 223) begin
                check("draw_running_224", game_running, 1);
                check("draw_cnt_224", move_cnt, 224);
            end
        end
        check("draw_not_running", game_running, 0);
        check("draw_winner", winner, 2'b00);
        check("draw_cnt", move_cnt, 225);
        w0 = n_write;
        hum_req = 1'b1; hum_i = 4'd0; hum_j = 4'd0;
        tick();
        hum_req = 1'b0;
        repeat (4) tick();
        check("draw_no_write", n_write, w0);

        // Game 4: human black vs AI white, undo requests.
        start_game(1'b1, 1'b0);
        play(1'b0, 4'd1, 4'd1, 1'b0, 1'b0);
        t0 = n_retract;
        retract_req = 1'b1;
        tick();
        retract_req = 1'b0;
        repeat (3) tick();
        check("retract_ai_owner_ignored", n_retract, t0);
        check("retract_ai_owner_cnt", move_cnt, 1);
        play(1'b1, 4'd2, 4'd2, 1'b1, 1'b0);
        play(1'b0, 4'd3, 4'd3, 1'b0, 1'b0);
        play(1'b1, 4'd4, 4'd4, 1'b1, 1'b0);
        check("g4_cnt4", move_cnt, 4);
        check("g4_player", crt_player, 0);
        w0 = n_write; a0 = n_ai_start; t0 = n_retract;
`ifdef GOBANG_RETRACT_EN
        retract_req = 1'b1;
        hum_req = 1'b1; hum_i = 4'd5; hum_j = 4'd5;
        tick();
        retract_req = 1'b0;
        hum_req = 1'b0;
        check("retract_pulse1", retract, 1);
        tick();
        check("retract_pulse2", retract, 1);
        tick();
        check("retract_end", retract, 0);
        repeat (3) tick();
        check("retract_count", n_retract, t0 + 2);
        check("retract_cnt", move_cnt, 2);
        check("retract_player", crt_player, 0);
        check("retract_beats_move", n_write, w0);
        check("retract_no_ai_start", n_ai_start, a0);
        play(1'b0, 4'd5, 4'd5, 1'b0, 1'b0);
        check("after_retract_cnt", move_cnt, 3);
`else
        retract_req = 1'b1;
        tick();
        retract_req = 1'b0;
        repeat (3) tick();
        check("retract_disabled", n_retract, t0);
        check("retract_disabled_cnt", move_cnt, 4);
        check("retract_disabled_player", crt_player, 0);
`endif
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/gobang_move_ctrl.md
# gobang_move_ctrl

Move sequencer for the gobang game. It owns the turn, arbitrates move requests from the human input path (cursor/mouse click) and the AI strategy engine, and checks that the target cell is empty through the datapath's consider port. It issues the single-cycle write/retract/clr pulses to the board datapath and round counter, and starts the win checker after each placement. It drives `crt_player`, `game_running` and `winner` for the display.

## Interface
- `MAX_MOVES`, 225: ply count at which the game ends in a draw.
- `CNT_W`, 8: width of `move_cnt`.

- `clk` in 1: system clock.
- `rst_p` in 1: synchronous, active-high reset.
- `start` in 1: pulse; begin a new game, legal in any state.
- `black_is_player` / `white_is_player` in 1: side is human when 1, AI when 0; sampled at `start`.
- `hum_req` in 1, `hum_i` / `hum_j` in 4: human move request and target cell.
- `ai_req` in 1, `ai_i` / `ai_j` in 4: AI move request and target cell.
- `retract_req` in 1: human undo request.
- `grid_i` in 9: datapath row window; bit 4 = considered cell, 1 = empty; valid one cycle after `consider_*` changes.
- `chk_done` in 1, `chk_win` in 1: win-checker completion and result for the last placed stone.
- `consider_i` / `consider_j` out 4: cell query to the datapath.
- `clr` out 1: board/counter clear pulse.
- `write` out 1, `write_i` / `write_j` out 4, `write_color` out 1: placement pulse and data (0 black, 1 white).
- `retract` out 1: undo-one-ply pulse.
- `ai_start` out 1: pulse telling the AI to compute a move.
- `chk_start` out 1: pulse starting the win checker.
- `reject` out 1: pulse for an illegal request (occupied cell or coordinate >14).
- `crt_player` out 1: side to move (0 black).
- `game_running` out 1: game is in progress.
- `winner` out 2: [1] black won, [0] white won, 00 no winner or draw.
- `move_cnt` out CNT_W: plies on the board.

## Operation
- States: IDLE, CLEAR, WAIT_MOVE, QUERY, CHECK, WRITE, JUDGE, RETRACT, OVER.
- Reset: IDLE. All pulse outputs are 0. `crt_player`=0, `game_running`=0, `winner`=00, `move_cnt`=0. `consider_*` and `write_*` are 0.
- `start`, from any state: go to CLEAR. Pulse `clr` for 1 cycle, clear `move_cnt` and `winner`, set `crt_player`=0 and `game_running`=1, then go to WAIT_MOVE. `start` has top priority over every other event.
- The owner of the turn is human if the side-to-move's `*_is_player` bit is 1, otherwise AI.
- WAIT_MOVE:
  - On entry with an AI owner: pulse `ai_start` once.
  - Requests from the non-owner source are ignored.
  - An owner request with i or j >14: pulse `reject` and stay in WAIT_MOVE.
  - A valid owner request: latch i/j, drive `consider_*`, go to QUERY.
- QUERY: wait one cycle for the datapath to respond. Then go to CHECK.
- CHECK:
  - `grid_i[4]`=0 (occupied): pulse `reject`, return to WAIT_MOVE. No `ai_start` is re-issued; the AI owns the retry.
  - `grid_i[4]`=1 (empty): go to WRITE.
- WRITE: 1-cycle `write` with the latched i/j and `write_color`=`crt_player`. Increment `move_cnt`, then go to JUDGE.
- JUDGE: pulse `chk_start` on entry, then wait for `chk_done`.
  - `chk_win`=1: set `winner` bit for `crt_player`, clear `game_running`, go to OVER.
  - Otherwise, if `move_cnt`==MAX_MOVES: draw. `winner`=00, clear `game_running`, go to OVER.
  - Otherwise: toggle `crt_player` and go to WAIT_MOVE.
- OVER: hold all outputs. Only `start` leaves this state.
- A simultaneous `retract_req` and move request in WAIT_MOVE: retract wins.

## Timing
- Human move: `hum_req` sampled at cycle 0. `consider_*` is valid at cycle 1, CHECK runs at cycle 2, `write` is high in cycle 3, and `chk_start` is high in cycle 4.
- The earliest next-turn WAIT_MOVE is 1 cycle after `chk_done`.
- Every pulse output is exactly 1 cycle wide.
- `move_cnt` saturates; it never wraps.
- Requests arriving outside WAIT_MOVE are dropped, not queued.

## Configuration
- `GOBANG_RETRACT_EN` defined: undo support is compiled in.
  - `retract_req` is honoured in WAIT_MOVE only when the owner is human.
  - Plies undone: 1 if both sides are human, otherwise 2 (the human's own stone plus the AI reply).
  - The request is ignored when `move_cnt` < plies.
  - RETRACT issues one `retract` pulse per cycle, decrements `move_cnt` once per pulse, and toggles `crt_player` once per pulse. It then returns to WAIT_MOVE.
- Macro undefined: `retract_req` is ignored, `retract` is tied to 0, and the RETRACT state is absent.

## Test plan
- Reset, then `start` with both sides human: `clr` pulse 1 cycle later, `game_running`=1, `crt_player`=0, `move_cnt`=0.
- Human requests (7,7) on an empty board: `write` 3 cycles later with i=7, j=7, color 0. Then `chk_start`; on `chk_done` with `chk_win`=0, `crt_player`=1 and `move_cnt`=1.
- Request (7,7) again with `grid_i[4]`=0: `reject` pulse, no `write`, `crt_player` unchanged. Request (15,3): `reject` with no query.
- White is AI: after black's move, `ai_start` pulses once; `hum_req` is ignored; `ai_req` (8,8) produces a write with color 1.
- `chk_win`=1 on a white move: `winner`=01, `game_running`=0, and further requests are ignored until `start`.
- With `GOBANG_RETRACT_EN`, human-vs-AI, `move_cnt`=4: `retract_req` produces two consecutive `retract` pulses, leaves `move_cnt`=2 with `crt_player` unchanged. With `move_cnt`=1 the request is ignored.
